// File: rtl/clk_monitor.sv
// -----------------------------------------------------------------------------
// clk_monitor
//
// Measures an asynchronous clock-like signal (sig_in) against the local clock
// CLK. Each rise-to-rise interval is reported as a period and a high time in
// CLK cycles. Two consecutive in-range periods assert locked; an out-of-range
// period or a missing rising edge raises a sticky fault.
//
// Parameters
//   CNT_W      : width of the period / high-time counters
//   MIN_PERIOD : smallest in-range period in CLK cycles
//   MAX_PERIOD : largest in-range period in CLK cycles
//   TIMEOUT    : CLK cycles without a rising edge before a fault (< 2**CNT_W)
//
// Ports
//   CLK        : in  - the single clock, all logic on its rising edge
//   RST        : in  - synchronous active-high reset
//   enable     : in  - monitor enable; low returns to IDLE and clears status
//   sig_in     : in  - asynchronous signal under test
//   period     : out - last measured rise-to-rise period (CLK cycles)
//   high_time  : out - high duration of the last measured period (CLK cycles)
//   meas_valid : out - one-cycle pulse when period/high_time update
//   locked     : out - two consecutive in-range periods seen
//   fault      : out - sticky timeout / out-of-range indication
// -----------------------------------------------------------------------------
module clk_monitor #(
   parameter int CNT_W      = 16,
   parameter int MIN_PERIOD = 8,
   parameter int MAX_PERIOD = 400,
   parameter int TIMEOUT    = 1000
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             enable,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             locked,
   output logic             fault
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      FAULT   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t           state_q, state_d;
   logic             sync1_q, sync2_q, prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             meas_valid_q, meas_valid_d;
   logic [1:0]       good_q, good_d;
   logic             locked_q, locked_d;
   logic             fault_q, fault_d;

   logic             rise, fall;
   logic [CNT_W-1:0] cnt_inc;
   logic             timeout_hit;
   logic             in_range;

   // Edges are taken between the synchronized value and its delayed copy, so
   // the first synchronizer flop (possibly metastable) is never decoded.
   assign rise = sync2_q & ~prev_q;
   assign fall = ~sync2_q & prev_q;

   // cnt counts cycles since the last rise; cnt+1 is the interval length the
   // current cycle would close. cnt stops at TIMEOUT-1, so this cannot wrap.
   assign cnt_inc     = cnt_q + CNT_W'(1);
   assign timeout_hit = (cnt_inc >= TIMEOUT_C);
   assign in_range    = (cnt_inc >= MIN_C) && (cnt_inc <= MAX_C);

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      cnt_d        = cnt_q;
      hcnt_d       = hcnt_q;
      period_d     = period_q;
      high_d       = high_q;
      meas_valid_d = 1'b0;
      good_d       = good_q;
      locked_d     = locked_q;
      fault_d      = fault_q;

      if (!enable) begin
         // Status is cleared, last measurement is kept.
         state_d  = IDLE;
         cnt_d    = '0;
         hcnt_d   = '0;
         good_d   = 2'd0;
         locked_d = 1'b0;
         fault_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               // Leaving with cnt at zero gives ARM a fresh timeout window.
               cnt_d   = '0;
               hcnt_d  = '0;
               state_d = ARM;
            end

            ARM: begin
               // The first rise only opens a measurement window.
               if (rise) begin
                  cnt_d   = '0;
                  hcnt_d  = '0;
                  state_d = MEASURE;
               end else if (timeout_hit) begin
                  good_d   = 2'd0;
                  locked_d = 1'b0;
                  fault_d  = 1'b1;
                  state_d  = FAULT;
               end else begin
                  cnt_d = cnt_inc;
               end
            end

            MEASURE: begin
               // Rise is checked before timeout so a rise landing exactly on
               // the timeout cycle still produces a measurement.
               if (rise) begin
                  period_d     = cnt_inc;
                  high_d       = hcnt_q;
                  meas_valid_d = 1'b1;
                  cnt_d        = '0;
                  hcnt_d       = '0;
                  if (in_range) begin
                     good_d   = (good_q == 2'd2) ? 2'd2 : good_q + 2'd1;
                     locked_d = (good_q != 2'd0);
                  end else begin
                     good_d   = 2'd0;
                     locked_d = 1'b0;
                     fault_d  = 1'b1;
                     state_d  = FAULT;
                  end
               end else if (timeout_hit) begin
                  good_d   = 2'd0;
                  locked_d = 1'b0;
                  fault_d  = 1'b1;
                  state_d  = FAULT;
               end else begin
                  cnt_d = cnt_inc;
                  if (fall) begin
                     hcnt_d = cnt_inc;
                  end
               end
            end

            FAULT: begin
               // Parked until enable drops or RST.
               fault_d = 1'b1;
            end

            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments make every register sample the values
      // from before this edge, independent of statement order.
      if (RST) begin
         state_q      <= IDLE;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         prev_q       <= 1'b0;
         cnt_q        <= '0;
         hcnt_q       <= '0;
         period_q     <= '0;
         high_q       <= '0;
         meas_valid_q <= 1'b0;
         good_q       <= 2'd0;
         locked_q     <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= sig_in;
         sync2_q      <= sync1_q;
         prev_q       <= sync2_q;
         cnt_q        <= cnt_d;
         hcnt_q       <= hcnt_d;
         period_q     <= period_d;
         high_q       <= high_d;
         meas_valid_q <= meas_valid_d;
         good_q       <= good_d;
         locked_q     <= locked_d;
         fault_q      <= fault_d;
      end
   end

   assign period     = period_q;
   assign high_time  = high_q;
   assign meas_valid = meas_valid_q;
   assign locked     = locked_q;
   assign fault      = fault_q;

endmodule
